// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if
//   Bundles the fetch stage's decode-side control, ROM bus and IF/ID register
//   outputs so the stage and its environment connect through one port.
//
//   Signals (direction as seen by the fetch stage):
//     stall_i          in   hold PC and IF/ID register this cycle
//     branch_taken_i   in   redirect PC and flush IF/ID
//     branch_target_i  in   redirect word index (unsigned)
//     instr_i          in   ROM data for pc_o, valid in the same cycle
//     pc_o             out  ROM word address
//     ifid_instr_o     out  registered instruction to decode
//     ifid_pc_o        out  registered PC of ifid_instr_o
//     ifid_valid_o     out  ifid_* holds a real instruction (0 = bubble)
//     done_o           out  fetch halted
//
//   Modports:
//     master  the fetch stage itself
//     slave   the surrounding decode logic / ROM / testbench
// ----------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int unsigned N = 32
);
  logic         stall_i;
  logic         branch_taken_i;
  logic [N-1:0] branch_target_i;
  logic [N-1:0] instr_i;
  logic [N-1:0] pc_o;
  logic [N-1:0] ifid_instr_o;
  logic [N-1:0] ifid_pc_o;
  logic         ifid_valid_o;
  logic         done_o;

  modport master (
    input  stall_i, branch_taken_i, branch_target_i, instr_i,
    output pc_o, ifid_instr_o, ifid_pc_o, ifid_valid_o, done_o
  );

  modport slave (
    output stall_i, branch_taken_i, branch_target_i, instr_i,
    input  pc_o, ifid_instr_o, ifid_pc_o, ifid_valid_o, done_o
  );
endinterface

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage directly upstream of a combinational instruction
//   ROM. Owns the word-indexed program counter, captures the returned
//   instruction into the IF/ID register, and handles decode stall, branch
//   redirect with a one-bubble flush, and end-of-program halt.
//
//   Parameters:
//     N         datapath / PC width in bits
//     INS       number of ROM words; PC stays within 0..INS-1
//     RESET_PC  PC loaded at reset (must be < INS)
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    fetch_stage_if.master (control in, ROM bus, IF/ID outputs)
//
//   Every output is driven straight from a flop, so there is no
//   combinational path from any input to any output.
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned N        = 32,
  parameter int unsigned INS      = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  localparam logic [N-1:0] INS_W      = N'(INS);
  localparam logic [N-1:0] LAST_PC    = N'(INS - 1);
  localparam logic [N-1:0] RESET_PC_W = N'(RESET_PC);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t       state_q,      state_d;
  logic [N-1:0] pc_q,         pc_d;
  logic [N-1:0] ifid_instr_q, ifid_instr_d;
  logic [N-1:0] ifid_pc_q,    ifid_pc_d;
  logic         ifid_valid_q, ifid_valid_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC_W;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Next-state logic. Priority: branch, stall, halt, normal fetch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;

    if (bus.branch_taken_i) begin
      // Flush the instruction fetched down the wrong path; ifid_pc keeps its
      // last value so decode still sees a meaningful PC on the bubble.
      ifid_valid_d = 1'b0;
      ifid_instr_d = '0;
      if (bus.branch_target_i < INS_W) begin
        pc_d    = bus.branch_target_i;
        state_d = RUN;
      end else begin
        // Out-of-range target: keep the old in-range PC so the ROM is never
        // addressed outside its depth, and stop fetching.
        state_d = HALT;
      end
    end else if (bus.stall_i) begin
      // Hold everything.
    end else if (state_q == HALT) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = '0;
    end else begin
      ifid_instr_d = bus.instr_i;
      ifid_pc_d    = pc_q;
      ifid_valid_d = 1'b1;
      if (pc_q == LAST_PC) begin
        state_d = HALT;
      end else begin
        pc_d = pc_q + N'(1);
      end
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.ifid_instr_o = ifid_instr_q;
  assign bus.ifid_pc_o    = ifid_pc_q;
  assign bus.ifid_valid_o = ifid_valid_q;
  assign bus.done_o       = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed-vector bench for fetch_stage. The driver applies inputs on the
//   falling edge and queues the hand-computed outputs expected after the next
//   rising edge; a monitor pops and compares shortly after each rising edge.
//   Asynchronous-reset checks are queued mid-cycle and compared on an event.
//   ROM model: word i = 0x100 + i for i in 0..9.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int unsigned N   = 32;
  localparam int unsigned INS = 10;

  typedef struct {
    string        name;
    logic [N-1:0] pc;
    logic [N-1:0] ipc;
    logic [N-1:0] iins;
    logic         iv;
    logic         dn;
  } exp_t;

  logic clk;
  logic rst_n;

  fetch_stage_if #(.N(N)) bus ();

  fetch_stage #(.N(N), .INS(INS), .RESET_PC(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [N-1:0] rom_word(input logic [N-1:0] a);
    if (a < N'(INS)) return N'(32'h100) + a;
    return 32'hDEAD_BEEF;
  endfunction

  assign bus.instr_i = rom_word(bus.pc_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  event chk_ev;

  task automatic check(input string nm, input string fld,
                       input logic [N-1:0] act, input logic [N-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  task automatic compare_all(input exp_t e);
    check(e.name, "pc_o",         bus.pc_o,         e.pc);
    check(e.name, "ifid_pc_o",    bus.ifid_pc_o,    e.ipc);
    check(e.name, "ifid_instr_o", bus.ifid_instr_o, e.iins);
    check(e.name, "ifid_valid_o", N'(bus.ifid_valid_o), N'(e.iv));
    check(e.name, "done_o",       N'(bus.done_o),       N'(e.dn));
  endtask

  // Edge monitor: sample 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) compare_all(exp_q.pop_front());
  end

  // Mid-cycle monitor for asynchronous-reset checks.
  initial begin
    forever begin
      @(chk_ev);
      if (exp_q.size() > 0) compare_all(exp_q.pop_front());
    end
  end

  task automatic push(input string nm, input logic [N-1:0] pc,
                      input logic [N-1:0] ipc, input logic [N-1:0] iins,
                      input logic iv, input logic dn);
    exp_t e;
    e.name = nm; e.pc = pc; e.ipc = ipc; e.iins = iins; e.iv = iv; e.dn = dn;
    exp_q.push_back(e);
  endtask

  // Apply inputs for the coming rising edge, queue the expected result,
  // then move to the next falling edge.
  task automatic step(input string nm, input logic st, input logic br,
                      input logic [N-1:0] tgt,
                      input logic [N-1:0] pc, input logic [N-1:0] ipc,
                      input logic [N-1:0] iins, input logic iv, input logic dn);
    bus.stall_i         = st;
    bus.branch_taken_i  = br;
    bus.branch_target_i = tgt;
    push(nm, pc, ipc, iins, iv, dn);
    @(negedge clk);
  endtask

  task automatic run_from_reset(input string tag);
    step({tag, "_e1"}, 0, 0, 0, 1, 0, 32'h100, 1, 0);
    step({tag, "_e2"}, 0, 0, 0, 2, 1, 32'h101, 1, 0);
    step({tag, "_e3"}, 0, 0, 0, 3, 2, 32'h102, 1, 0);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n               = 1'b0;
    bus.stall_i         = 1'b0;
    bus.branch_taken_i  = 1'b0;
    bus.branch_target_i = '0;

    #2;
    push("reset", 0, 0, 0, 0, 0);
    ->chk_ev;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch after reset
    run_from_reset("s1");

    // Stall for two edges, then resume
    step("s2_stall1", 1, 0, 0, 3, 2, 32'h102, 1, 0);
    step("s2_stall2", 1, 0, 0, 3, 2, 32'h102, 1, 0);
    step("s2_resume", 0, 0, 0, 4, 3, 32'h103, 1, 0);

    // Branch wins over stall; one bubble, then target instruction
    step("s3_branch", 1, 1, 7, 7, 3, 0,       0, 0);
    step("s3_target", 0, 0, 0, 8, 7, 32'h107, 1, 0);

    // Run to the last word and halt
    step("s4_pc8",    0, 0, 0, 9, 8, 32'h108, 1, 0);
    step("s4_last",   0, 0, 0, 9, 9, 32'h109, 1, 1);
    step("s4_halt1",  0, 0, 0, 9, 9, 0,       0, 1);
    step("s4_halt2",  0, 0, 0, 9, 9, 0,       0, 1);
    step("s4_hstall", 1, 0, 0, 9, 9, 0,       0, 1);

    // Out-of-range redirects keep HALT; in-range ones leave it
    step("s5_br12",   0, 1, 12, 9, 9, 0,       0, 1);
    step("s5_br10",   0, 1, 10, 9, 9, 0,       0, 1);
    step("s5_br9",    0, 1, 9,  9, 9, 0,       0, 0);
    step("s5_re9",    0, 0, 0,  9, 9, 32'h109, 1, 1);
    step("s5_br0",    0, 1, 0,  0, 9, 0,       0, 0);
    step("s5_f0",     0, 0, 0,  1, 0, 32'h100, 1, 0);
    step("s5_f1",     0, 0, 0,  2, 1, 32'h101, 1, 0);
    step("s5_f2",     0, 0, 0,  3, 2, 32'h102, 1, 0);

    // Asynchronous reset mid-cycle, away from any rising edge
    #1;
    rst_n = 1'b0;
    #1;
    push("s6_async", 0, 0, 0, 0, 0);
    ->chk_ev;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_from_reset("s6");

    @(negedge clk);
    check("drain", "queue_size", N'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
